rf_scoreboard: RTL and testbench
================================

// Module: rf_scoreboard
// PURPOSE
//   Tracks in-flight writes to the 16-entry register file and gates instruction issue
//   so that no instruction reads a register with an outstanding write (RAW hazard).
//   Sits between decode/issue and the register file write-back path.
//   Keeps one pending-write counter per register; R0 is hard-wired zero and never tracked.
//   Also provides a sticky error flag on write-back underflow and a stall-cycle counter.
// PARAMETERS
//   CNT_W        2   width of each per-register pending-write counter; max in flight = 2^CNT_W-1
//   STALL_CNT_W  16  width of the saturating stall-cycle counter
// PORTS
//   clk            in   1            clock, all state updates on rising edge
//   rst            in   1            reset, asynchronous, active-low
//   issue_valid    in   1            issue stage presents an instruction
//   issue_src1     in   4            first source register id
//   issue_use_src1 in   1            instruction reads issue_src1
//   issue_src2     in   4            second source register id
//   issue_use_src2 in   1            instruction reads issue_src2
//   issue_dst      in   4            destination register id
//   issue_wr       in   1            instruction writes issue_dst
//   issue_ready    out  1            combinational; instruction may issue this cycle
//   wb_valid       in   1            one pending write retires this cycle
//   wb_dst         in   4            register id of the retiring write
//   flush          in   1            discard all outstanding writes (pipeline flush)
//   busy_vec       out  16           registered; bit i = 1 iff counter[i] != 0 (bit 0 always 0)
//   stall_cnt      out  STALL_CNT_W  registered; cycles with issue_valid=1 and issue_ready=0
//   err_underflow  out  1            registered, sticky; write-back to a register with counter 0
// BEHAVIOUR
//   Reset (rst=0, async): all counters=0, busy_vec=0, stall_cnt=0, err_underflow=0.
//   Fire: issue_fire = issue_valid & issue_ready. wb_hit = wb_valid & (wb_dst != 0).
//   issue_ready = !flush & !haz1 & !haz2 & !sat, where
//     haz1 = issue_use_src1 & (issue_src1 != 0) & (counter[issue_src1] != 0)
//     haz2 = same for src2
//     sat  = issue_wr & (issue_dst != 0) & (counter[issue_dst] == 2^CNT_W-1)
//   Hazard checks use registered counters only; a same-cycle wb does not bypass (1-cycle penalty).
//   WAW allowed: multiple writes to one register may be in flight up to the counter max.
//   Counter update per register i != 0, each cycle:
//     flush=1                      -> counter := 0 (overrides issue and wb)
//     inc = issue_fire & issue_wr & issue_dst==i; dec = wb_hit & wb_dst==i & counter!=0
//     inc & dec -> unchanged; inc only -> +1; dec only -> -1; neither -> unchanged
//   Underflow: wb_hit with counter[wb_dst]==0 and flush=0 -> counter stays 0, err_underflow := 1.
//   err_underflow cleared only by reset (not by flush).
//   R0: issue_dst=0 or wb_dst=0 never changes state or raises an error; src id 0 never hazards.
//   stall_cnt: +1 each cycle issue_valid & !issue_ready (includes flush cycles); saturates
//     at all-ones, never wraps.
//   busy_vec reflects the counters after the edge (1-cycle latency from fire/wb).
//   Reset asserted mid-operation: all state cleared immediately; outstanding writes forgotten.
// TESTING
//   1 issue dst=R3 (wr=1), next cycle issue src1=R3 -> issue_ready=0, busy_vec=16'h0008;
//     wb_dst=R3 -> following cycle issue_ready=1, busy_vec=0, stall_cnt counted stalled cycles.
//   2 three issues with dst=R5 (CNT_W=2) -> counter=3, fourth issue with dst=R5 -> issue_ready=0;
//     one wb R5 -> ready; same-cycle issue R5 + wb R5 -> counter unchanged.
//   3 issue dst=R0 then src1=R0 -> issue_ready=1 always, busy_vec=0;
//     wb_dst=R0 with no pending write -> err_underflow stays 0.
//   4 wb_dst=R7 with counter 0 -> err_underflow=1 next cycle, stays 1 after flush, 0 after rst.
//   5 pend R2, R9, R14 then flush=1 with simultaneous issue_valid and wb_dst=R2 -> issue_ready=0,
//     busy_vec=0 next cycle, no underflow.
//   6 hold a hazard stall for 2^STALL_CNT_W+5 cycles -> stall_cnt saturates at all-ones;
//     async rst pulse mid-stall -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: RAW-hazard scoreboard for a 16-entry register file.
// Tracks pending writes per register, gates issue on hazards, reports
// write-back underflow (sticky) and counts stalled issue cycles.
module rf_scoreboard #(
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [3:0]             issue_src1,
  input  logic                   issue_use_src1,
  input  logic [3:0]             issue_src2,
  input  logic                   issue_use_src2,
  input  logic [3:0]             issue_dst,
  input  logic                   issue_wr,
  output logic                   issue_ready,
  input  logic                   wb_valid,
  input  logic [3:0]             wb_dst,
  input  logic                   flush,
  output logic [15:0]            busy_vec,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   err_underflow
);

  localparam int NREG = 16;
  localparam logic [CNT_W-1:0]       CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

  logic [CNT_W-1:0]       cnt_q [NREG];
  logic [CNT_W-1:0]       cnt_d [NREG];
  logic [15:0]            busy_q, busy_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   err_q, err_d;

  logic haz1, haz2, sat, issue_fire, wb_hit;

  // Hazard detection from registered counters only (no write-back bypass).
  always_comb begin
    haz1 = issue_use_src1 & (issue_src1 != 4'd0) & (cnt_q[issue_src1] != CNT_ZERO);
    haz2 = issue_use_src2 & (issue_src2 != 4'd0) & (cnt_q[issue_src2] != CNT_ZERO);
    sat  = issue_wr & (issue_dst != 4'd0) & (cnt_q[issue_dst] == CNT_MAX);
    issue_ready = ~flush & ~haz1 & ~haz2 & ~sat;
    issue_fire  = issue_valid & issue_ready;
    wb_hit      = wb_valid & (wb_dst != 4'd0);
  end

  // Next-state for counters, busy vector, sticky error and stall counter.
  always_comb begin
    busy_d  = 16'h0000;
    err_d   = err_q;
    stall_d = stall_q;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i == 0) begin
        // R0 is hard-wired zero and never tracked.
        cnt_d[i] = CNT_ZERO;
      end else if (flush) begin
        cnt_d[i] = CNT_ZERO;
      end else if ((issue_fire & issue_wr & (issue_dst == 4'(i))) &&
                   !(wb_hit & (wb_dst == 4'(i)) & (cnt_q[i] != CNT_ZERO))) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (!(issue_fire & issue_wr & (issue_dst == 4'(i))) &&
                   (wb_hit & (wb_dst == 4'(i)) & (cnt_q[i] != CNT_ZERO))) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      busy_d[i] = (i != 0) && (cnt_d[i] != CNT_ZERO);
    end
    // A retiring write with nothing pending is a protocol error; flush masks it.
    if (wb_hit && !flush && (cnt_q[wb_dst] == CNT_ZERO)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    // Stalled cycles include flush cycles; the counter saturates, never wraps.
    if (issue_valid && !issue_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      busy_q  <= 16'h0000;
      stall_q <= {STALL_CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      busy_q  <= busy_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign busy_vec      = busy_q;
  assign stall_cnt     = stall_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed testbench for rf_scoreboard (CNT_W=2, STALL_CNT_W=16).
module tb_rf_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [3:0]  issue_src1;
  logic        issue_use_src1;
  logic [3:0]  issue_src2;
  logic        issue_use_src2;
  logic [3:0]  issue_dst;
  logic        issue_wr;
  logic        issue_ready;
  logic        wb_valid;
  logic [3:0]  wb_dst;
  logic        flush;
  logic [15:0] busy_vec;
  logic [15:0] stall_cnt;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  rf_scoreboard #(.CNT_W(2), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_src1(issue_src1), .issue_use_src1(issue_use_src1),
    .issue_src2(issue_src2), .issue_use_src2(issue_use_src2),
    .issue_dst(issue_dst), .issue_wr(issue_wr), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt), .err_underflow(err_underflow)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_src1 = 4'd0; issue_use_src1 = 1'b0;
    issue_src2 = 4'd0; issue_use_src2 = 1'b0; issue_dst = 4'd0; issue_wr = 1'b0;
    wb_valid = 1'b0; wb_dst = 4'd0; flush = 1'b0;
  endtask

  // Advance past the next rising edge; outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr_dst(input logic [3:0] d);
    idle();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_dst = d;
  endtask

  task automatic wb(input logic [3:0] d);
    idle();
    wb_valid = 1'b1; wb_dst = d;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #1;
    chk("reset_busy", 32'(busy_vec), 32'h0);
    chk("reset_stall", 32'(stall_cnt), 32'h0);
    chk("reset_err", 32'(err_underflow), 32'h0);
    #10 rst = 1'b1;
    tick();

    // ---- 1: RAW hazard on R3 ----
    issue_wr_dst(4'd3);
    #1 chk("t1_ready_first", 32'(issue_ready), 32'h1);
    tick();
    chk("t1_busy_r3", 32'(busy_vec), 32'h0008);
    idle(); issue_valid = 1'b1; issue_use_src1 = 1'b1; issue_src1 = 4'd3;
    #1 chk("t1_ready_haz", 32'(issue_ready), 32'h0);
    tick();
    chk("t1_stall1", 32'(stall_cnt), 32'h1);
    wb_valid = 1'b1; wb_dst = 4'd3;
    #1 chk("t1_ready_nobypass", 32'(issue_ready), 32'h0);
    tick();
    chk("t1_busy_clear", 32'(busy_vec), 32'h0);
    chk("t1_stall2", 32'(stall_cnt), 32'h2);
    wb_valid = 1'b0;
    #1 chk("t1_ready_after_wb", 32'(issue_ready), 32'h1);
    tick();
    chk("t1_stall_hold", 32'(stall_cnt), 32'h2);

    // ---- 2: WAW up to counter max on R5 ----
    for (int k = 0; k < 3; k++) begin
      issue_wr_dst(4'd5);
      #1 chk("t2_ready_fill", 32'(issue_ready), 32'h1);
      tick();
    end
    chk("t2_busy_r5", 32'(busy_vec), 32'h0020);
    issue_wr_dst(4'd5);
    #1 chk("t2_ready_sat", 32'(issue_ready), 32'h0);
    tick();
    chk("t2_stall3", 32'(stall_cnt), 32'h3);
    wb(4'd5);
    tick();
    issue_wr_dst(4'd5); wb_valid = 1'b1; wb_dst = 4'd5;
    #1 chk("t2_ready_after_wb", 32'(issue_ready), 32'h1);
    tick();
    issue_wr_dst(4'd5);
    #1 chk("t2_ready_cnt2", 32'(issue_ready), 32'h1);
    tick();
    issue_wr_dst(4'd5);
    #1 chk("t2_ready_cnt3", 32'(issue_ready), 32'h0);
    idle();
    for (int k = 0; k < 3; k++) begin
      wb(4'd5);
      tick();
    end
    idle();
    chk("t2_busy_drained", 32'(busy_vec), 32'h0);
    chk("t2_err_none", 32'(err_underflow), 32'h0);
    chk("t2_stall_hold", 32'(stall_cnt), 32'h3);

    // ---- 3: R0 never tracked ----
    issue_wr_dst(4'd0);
    tick();
    chk("t3_busy_r0", 32'(busy_vec), 32'h0);
    idle(); issue_valid = 1'b1; issue_use_src1 = 1'b1; issue_src1 = 4'd0;
    issue_use_src2 = 1'b1; issue_src2 = 4'd0;
    #1 chk("t3_ready_src0", 32'(issue_ready), 32'h1);
    tick();
    wb(4'd0);
    tick();
    idle();
    chk("t3_err_r0", 32'(err_underflow), 32'h0);

    // ---- 4: underflow sticky through flush, cleared by reset ----
    wb(4'd7);
    tick();
    idle();
    chk("t4_err_set", 32'(err_underflow), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_err_after_flush", 32'(err_underflow), 32'h1);
    rst = 1'b0;
    #2;
    chk("t4_err_after_rst", 32'(err_underflow), 32'h0);
    chk("t4_stall_after_rst", 32'(stall_cnt), 32'h0);
    rst = 1'b1;
    tick();

    // ---- 5: flush overrides issue and write-back ----
    issue_wr_dst(4'd2);  tick();
    issue_wr_dst(4'd9);  tick();
    issue_wr_dst(4'd14); tick();
    idle();
    chk("t5_busy_pend", 32'(busy_vec), 32'h4204);
    issue_wr_dst(4'd4); flush = 1'b1; wb_valid = 1'b1; wb_dst = 4'd2;
    #1 chk("t5_ready_flush", 32'(issue_ready), 32'h0);
    tick();
    idle();
    chk("t5_busy_flushed", 32'(busy_vec), 32'h0);
    chk("t5_err_none", 32'(err_underflow), 32'h0);
    chk("t5_stall_flush", 32'(stall_cnt), 32'h1);

    // ---- 6: stall counter saturation and async reset mid-stall ----
    issue_wr_dst(4'd1);
    tick();
    idle(); issue_valid = 1'b1; issue_use_src2 = 1'b1; issue_src2 = 4'd1;
    #1 chk("t6_ready_haz", 32'(issue_ready), 32'h0);
    for (int k = 0; k < 65530; k++) tick();
    chk("t6_stall_pre_sat", 32'(stall_cnt), 32'hFFFB);
    for (int k = 0; k < 11; k++) tick();
    chk("t6_stall_sat", 32'(stall_cnt), 32'hFFFF);
    chk("t6_busy_r1", 32'(busy_vec), 32'h0002);
    rst = 1'b0;
    #2;
    chk("t6_rst_busy", 32'(busy_vec), 32'h0);
    chk("t6_rst_stall", 32'(stall_cnt), 32'h0);
    chk("t6_rst_err", 32'(err_underflow), 32'h0);
    rst = 1'b1;
    #1 chk("t6_ready_after_rst", 32'(issue_ready), 32'h1);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
